// File: rtl/axis_s2mm_pattern_gen.sv
// axis_s2mm_pattern_gen: AXI4-Stream test-pattern source for the DMA S2MM port.
// Emits num_pkts packets (0 = continuous) of pkt_len beats with tlast on the final
// beat of each packet and a programmable idle gap between packets.
// Optional feature macro: PATTERN_GEN_LFSR_EN (mode 2 = 32-bit LFSR; otherwise mode 2 = mode 0).
//
// Handshake: a beat transfers on a rising FCLK_CLK0 edge when m_axis_tvalid && m_axis_tready.
// Once tvalid is high it stays high, and tdata/tlast stay unchanged, until that beat transfers.
// tvalid never depends combinationally on tready.
module axis_s2mm_pattern_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    FCLK_CLK0,
  input  logic                    FCLK_RESET0,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic [CNT_WIDTH-1:0]    num_pkts,
  input  logic [GAP_WIDTH-1:0]    gap_cycles,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [1:0]              dbg_state
);

  localparam int HALF = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic                   enable_q;
  logic [1:0]             mode_q;
  logic [LEN_WIDTH-1:0]   len_m1_q;
  logic [CNT_WIDTH-1:0]   num_q;
  logic [GAP_WIDTH-1:0]   gap_q;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [LEN_WIDTH-1:0]   beat_idx;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [CNT_WIDTH-1:0]   pkt_cnt_inc;
  logic                   start;
  logic                   accept;
  logic                   last_accept;
  logic                   final_pkt;
`ifdef PATTERN_GEN_LFSR_EN
  logic [31:0]            lfsr_q;
`endif

  assign start       = (state == S_IDLE) && enable && !enable_q;
  assign accept      = m_axis_tvalid && m_axis_tready;
  assign last_accept = accept && m_axis_tlast;
  assign pkt_cnt_inc = pkt_cnt + CNT_WIDTH'(1);
  assign final_pkt   = (num_q != '0) && (pkt_cnt_inc == num_q);

  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = (state == S_SEND);
  assign m_axis_tlast  = (state == S_SEND) && (beat_idx == len_m1_q);
  assign busy          = (state == S_SEND) || (state == S_GAP);
  assign dbg_state     = state;

  // State register
  always_ff @(posedge FCLK_CLK0 or posedge FCLK_RESET0) begin
    if (FCLK_RESET0) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic: run start, packet end decisions, gap expiry, done release
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SEND;
      S_SEND: begin
        if (last_accept) begin
          if (final_pkt)            state_nxt = S_DONE;
          else if (!enable)         state_nxt = S_IDLE;
          else if (gap_q != '0)     state_nxt = S_GAP;
          else                      state_nxt = S_SEND;
        end
      end
      S_GAP:  if (gap_cnt == '0) state_nxt = S_SEND;
      S_DONE: if (!enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run configuration, beat/packet counters, gap timer, pattern state and done pulse
  always_ff @(posedge FCLK_CLK0 or posedge FCLK_RESET0) begin
    if (FCLK_RESET0) begin
      enable_q <= 1'b0;
      done     <= 1'b0;
      mode_q   <= '0;
      len_m1_q <= '0;
      num_q    <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      beat_idx <= '0;
      pkt_cnt  <= '0;
      data_q   <= '0;
`ifdef PATTERN_GEN_LFSR_EN
      lfsr_q   <= 32'h0000_0001;
`endif
    end else begin
      enable_q <= enable;
      done     <= (state_nxt == S_DONE) && (state != S_DONE);
      if (start) begin
        mode_q   <= mode;
        // A zero length is run as a one-beat packet
        len_m1_q <= (pkt_len == '0) ? '0 : pkt_len - LEN_WIDTH'(1);
        num_q    <= num_pkts;
        gap_q    <= gap_cycles;
        beat_idx <= '0;
        pkt_cnt  <= '0;
        data_q   <= (mode == 2'd3) ? DATA_WIDTH'(1) : '0;
`ifdef PATTERN_GEN_LFSR_EN
        lfsr_q   <= 32'h0000_0001;
`endif
      end else if (accept) begin
        if (m_axis_tlast) begin
          beat_idx <= '0;
          pkt_cnt  <= pkt_cnt_inc;
        end else begin
          beat_idx <= beat_idx + LEN_WIDTH'(1);
        end
        if (mode_q == 2'd3) data_q <= {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
        else                data_q <= data_q + DATA_WIDTH'(1);
`ifdef PATTERN_GEN_LFSR_EN
        // Taps 32,22,2,1 shifted in at the LSB
        lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
`endif
      end
      if (last_accept)
        gap_cnt <= gap_q - GAP_WIDTH'(1);
      else if ((state == S_GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
    end
  end

  // Output data pattern selection
  always_comb begin
    m_axis_tdata = data_q;
    case (mode_q)
      2'd1: m_axis_tdata = {HALF'(pkt_cnt), HALF'(beat_idx)};
`ifdef PATTERN_GEN_LFSR_EN
      2'd2: m_axis_tdata = DATA_WIDTH'(lfsr_q);
`endif
      default: m_axis_tdata = data_q;
    endcase
  end

endmodule

// File: tb/tb_axis_s2mm_pattern_gen.sv
// tb_axis_s2mm_pattern_gen: table-driven and randomized bench for axis_s2mm_pattern_gen.
// Expected beats come from a pattern model computed per packet/beat index.
module tb_axis_s2mm_pattern_gen;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [15:0]   pkt_len;
  logic [15:0]   num_pkts;
  logic [7:0]    gap_cycles;
  logic [W-1:0]  tdata;
  logic [W/8-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          busy;
  logic          done;
  logic [15:0]   pkt_cnt;
  logic [1:0]    dbg_state;

  axis_s2mm_pattern_gen dut (
    .FCLK_CLK0     (clk),
    .FCLK_RESET0   (rst),
    .enable        (enable),
    .mode          (mode),
    .pkt_len       (pkt_len),
    .num_pkts      (num_pkts),
    .gap_cycles    (gap_cycles),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .busy          (busy),
    .done          (done),
    .pkt_cnt       (pkt_cnt),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_pct  = 100;
  int beats_seen = 0;
  int done_cnt = 0;
  int exp_gap = 0;

  // Scoreboard: {tlast, tdata}
  logic [W:0] exp_q[$];

  typedef struct {
    int mode; int len; int n; int gap; int rdy; int exp_beats; int exp_cnt;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  // Reference model: every beat of every packet in order
  task automatic build_expected(input int m, input int len, input int n);
    int l;
    logic [31:0] k, lf, pv, iv, d;
    l  = (len == 0) ? 1 : len;
    k  = 0;
    lf = 32'h1;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < l; i++) begin
        pv = p;
        iv = i;
        case (m)
          0: d = k;
          1: d = {pv[15:0], iv[15:0]};
`ifdef PATTERN_GEN_LFSR_EN
          2: d = lf;
`else
          2: d = k;
`endif
          default: d = 32'h1 << (k % 32);
        endcase
        exp_q.push_back({(i == l - 1), d});
        k  = k + 1;
        lf = lfsr_next(lf);
      end
    end
  endtask

  // Ready driver
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1 tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: beat scoreboard, stall stability, gap length, done count
  initial begin : monitor
    logic prev_stall, prev_last, gap_trk;
    logic [W-1:0] prev_data;
    logic [W:0] e;
    int gap_len;
    prev_stall = 0; prev_last = 0; prev_data = '0; gap_trk = 0; gap_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        gap_trk = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", {tvalid, tlast, tdata}, {1'b1, prev_last, prev_data});
        if (gap_trk) begin
          if (!busy) gap_trk = 0;
          else if (tvalid) begin
            check("gap_len", gap_len, exp_gap);
            gap_trk = 0;
          end else gap_len++;
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", {tlast, tdata}, '0);
            if ({tlast, tdata} == '0) check("extra_beat_flag", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat", {tlast, tdata}, e);
          end
          beats_seen++;
          if (tlast) begin
            gap_trk = 1;
            gap_len = 0;
          end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        if (done) done_cnt++;
      end
    end
  end

  // Driver: one complete finite run, enable held until done
  task automatic run_cfg(input int m, input int len, input int n, input int gap,
                         input int rdy, input int exp_beats, input int exp_cnt);
    int b0, d0;
    bit got;
    @(posedge clk);
    #1;
    mode = m[1:0]; pkt_len = len[15:0]; num_pkts = n[15:0]; gap_cycles = gap[7:0];
    rdy_pct = rdy;
    exp_gap = gap;
    build_expected(m, len, n);
    b0 = beats_seen;
    d0 = done_cnt;
    enable = 1'b1;
    got = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(posedge clk);
      if (done_cnt != d0) got = 1;
    end
    check("done_seen", got, 1);
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("beat_count", beats_seen - b0, exp_beats);
    check("done_pulses", done_cnt - d0, 1);
    check("pkt_cnt", pkt_cnt, exp_cnt);
    check("queue_empty", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int b0, d0, l;
    bit got;
    vecs[0] = '{0, 4, 2, 0, 100, 8, 2};    // basic
    vecs[1] = '{0, 8, 1, 0, 50, 8, 1};     // backpressure
    vecs[2] = '{1, 3, 3, 5, 100, 9, 3};    // gap + {pkt,beat}
    vecs[3] = '{1, 5, 2, 2, 60, 10, 2};
    vecs[4] = '{0, 0, 3, 1, 100, 3, 3};    // zero length
    vecs[5] = '{3, 40, 1, 0, 70, 40, 1};   // walking one wrap
    vecs[6] = '{2, 6, 2, 3, 80, 12, 2};    // mode 2
    for (int r = 7; r < 10; r++) begin
      vecs[r].mode = $urandom_range(0, 3);
      vecs[r].len  = $urandom_range(0, 6);
      vecs[r].n    = $urandom_range(1, 4);
      vecs[r].gap  = $urandom_range(0, 3);
      vecs[r].rdy  = $urandom_range(30, 100);
      l = (vecs[r].len == 0) ? 1 : vecs[r].len;
      vecs[r].exp_beats = vecs[r].n * l;
      vecs[r].exp_cnt   = vecs[r].n;
    end

    rst = 1'b1; enable = 1'b0; mode = 0; pkt_len = 0; num_pkts = 0; gap_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("tkeep", tkeep, 4'hF);
    rst = 1'b0;

    for (int r = 0; r < 10; r++)
      run_cfg(vecs[r].mode, vecs[r].len, vecs[r].n, vecs[r].gap, vecs[r].rdy,
              vecs[r].exp_beats, vecs[r].exp_cnt);

    // Graceful stop in continuous mode during packet 2
    @(posedge clk);
    #1;
    mode = 0; pkt_len = 16; num_pkts = 0; gap_cycles = 0; rdy_pct = 100; exp_gap = 0;
    build_expected(0, 16, 2);
    b0 = beats_seen; d0 = done_cnt;
    enable = 1'b1;
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(posedge clk);
      if (beats_seen - b0 >= 21) got = 1;
    end
    check("stop_reach", got, 1);
    #1 enable = 1'b0;
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(posedge clk);
      if (!busy) got = 1;
    end
    check("stop_idle", got, 1);
    repeat (5) @(posedge clk);
    #1;
    check("stop_beats", beats_seen - b0, 32);
    check("stop_no_done", done_cnt - d0, 0);
    check("stop_pkt_cnt", pkt_cnt, 2);
    check("stop_tvalid", tvalid, 0);
    check("stop_queue", exp_q.size(), 0);
    exp_q.delete();

    // Reset in the middle of packet 2
    @(posedge clk);
    #1;
    mode = 0; pkt_len = 4; num_pkts = 3; gap_cycles = 0; rdy_pct = 100;
    build_expected(0, 4, 3);
    b0 = beats_seen;
    enable = 1'b1;
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(posedge clk);
      if (beats_seen - b0 >= 6) got = 1;
    end
    check("rst_reach", got, 1);
    #1;
    check("pre_rst_pkt_cnt", pkt_cnt, 1);
    rst = 1'b1;
    enable = 1'b0;
    #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_tdata", tdata, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    run_cfg(0, 4, 1, 0, 100, 4, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
